// File: rtl/soc_system_pio_edge.sv
// rtl/soc_system_pio_edge.sv - bidirectional PIO with per-bit edge capture, interrupt mask and set/clear registers
module soc_system_pio_edge #(
    parameter int               WIDTH       = 8,
    parameter logic [WIDTH-1:0] RESET_OUT   = '0,
    parameter logic [WIDTH-1:0] RESET_DIR   = '0,
    parameter int               EDGE_TYPE   = 0,
    parameter int               SYNC_STAGES = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [2:0]       address,
    input  logic             chipselect,
    input  logic             write_n,
    input  logic [31:0]      writedata,
    output logic [31:0]      readdata,
    inout  wire  [WIDTH-1:0] bidir_port,
    output logic             irq
);

    localparam logic [2:0] WARM_CYCLES = 3'(SYNC_STAGES + 1);

    logic             wr_strobe;
    logic [WIDTH-1:0] wdata;
    logic [31:0]      unused_wdata;

    logic [WIDTH-1:0] data_out;
    logic [WIDTH-1:0] data_dir;
    logic [WIDTH-1:0] irq_mask;
    logic [WIDTH-1:0] edge_capture;

    logic [WIDTH-1:0] sync_q [SYNC_STAGES];
    logic [WIDTH-1:0] data_in;
    logic [WIDTH-1:0] data_in_d;
    logic [WIDTH-1:0] edge_det;
    logic [WIDTH-1:0] capture_clr;

    logic [2:0]       warm_cnt;
    logic             warm_done;
    logic [31:0]      rd_mux;

    assign wr_strobe    = chipselect && !write_n;
    assign wdata        = writedata[WIDTH-1:0];
    assign unused_wdata = writedata;

    for (genvar i = 0; i < WIDTH; i++) begin : g_pin
        assign bidir_port[i] = data_dir[i] ? data_out[i] : 1'bz;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            data_out <= RESET_OUT;
            data_dir <= RESET_DIR;
            irq_mask <= '0;
        end else if (wr_strobe) begin
            case (address)
                3'd0:    data_out <= wdata;
                3'd1:    data_dir <= wdata;
                3'd2:    irq_mask <= wdata;
                3'd4:    data_out <= data_out | wdata;
                3'd5:    data_out <= data_out & ~wdata;
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < SYNC_STAGES; i++) begin
                sync_q[i] <= '0;
            end
            data_in_d <= '0;
        end else begin
            sync_q[0] <= bidir_port;
            for (int i = 1; i < SYNC_STAGES; i++) begin
                sync_q[i] <= sync_q[i-1];
            end
            data_in_d <= data_in;
        end
    end

    assign data_in = sync_q[SYNC_STAGES-1];

    always_comb begin
        edge_det = '0;
        if (EDGE_TYPE == 0) begin
            edge_det = data_in & ~data_in_d;
        end else if (EDGE_TYPE == 1) begin
            edge_det = ~data_in & data_in_d;
        end else begin
            edge_det = data_in ^ data_in_d;
        end
    end

    // The synchronizer fills from zero after reset; hold off capture until
    // the reset zeros have drained so static-high pins do not look like edges.
    assign warm_done = (warm_cnt == WARM_CYCLES);

    always_ff @(posedge clk) begin
        if (reset) begin
            warm_cnt <= '0;
        end else if (!warm_done) begin
            warm_cnt <= warm_cnt + 3'd1;
        end
    end

    assign capture_clr = (wr_strobe && address == 3'd3) ? wdata : '0;

    // Clear first, then OR in new edges so a simultaneous edge is never lost.
    always_ff @(posedge clk) begin
        if (reset) begin
            edge_capture <= '0;
        end else begin
            edge_capture <= (edge_capture & ~capture_clr) | (warm_done ? edge_det : '0);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            irq <= 1'b0;
        end else begin
            irq <= |(edge_capture & irq_mask);
        end
    end

    always_comb begin
        rd_mux = '0;
        case (address)
            3'd0:    rd_mux[WIDTH-1:0] = data_in;
            3'd1:    rd_mux[WIDTH-1:0] = data_dir;
            3'd2:    rd_mux[WIDTH-1:0] = irq_mask;
            3'd3:    rd_mux[WIDTH-1:0] = edge_capture;
            default: rd_mux = '0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            readdata <= '0;
        end else begin
            readdata <= rd_mux;
        end
    end

endmodule

// File: tb/tb_soc_system_pio_edge.sv
// tb/tb_soc_system_pio_edge.sv - directed self-checking bench for soc_system_pio_edge
module tb_soc_system_pio_edge;

    logic        clk = 1'b0;
    int          tests_run = 0;
    int          tests_failed = 0;

    logic        rst_a = 1'b1;
    logic [2:0]  addr_a = '0;
    logic        cs_a = 1'b0;
    logic        wn_a = 1'b1;
    logic [31:0] wd_a = '0;
    logic [31:0] rd_a;
    logic        irq_a;
    wire  [7:0]  pins_a;
    logic [7:0]  en_a = '0;
    logic [7:0]  val_a = '0;

    logic        rst_b = 1'b1;
    logic [2:0]  addr_b = '0;
    logic        cs_b = 1'b0;
    logic        wn_b = 1'b1;
    logic [31:0] wd_b = '0;
    logic [31:0] rd_b;
    logic        irq_b;
    wire  [31:0] pins_b;
    logic [31:0] en_b = '1;
    logic [31:0] val_b = 32'h8000_0000;

    always #5 clk = ~clk;

    for (genvar i = 0; i < 8; i++) begin : g_drv_a
        assign pins_a[i] = en_a[i] ? val_a[i] : 1'bz;
    end
    for (genvar i = 0; i < 32; i++) begin : g_drv_b
        assign pins_b[i] = en_b[i] ? val_b[i] : 1'bz;
    end

    soc_system_pio_edge #(.WIDTH(8), .EDGE_TYPE(0), .SYNC_STAGES(2)) dut_a (
        .clk(clk), .reset(rst_a), .address(addr_a), .chipselect(cs_a),
        .write_n(wn_a), .writedata(wd_a), .readdata(rd_a),
        .bidir_port(pins_a), .irq(irq_a)
    );

    soc_system_pio_edge #(.WIDTH(32), .EDGE_TYPE(2), .SYNC_STAGES(2)) dut_b (
        .clk(clk), .reset(rst_b), .address(addr_b), .chipselect(cs_b),
        .write_n(wn_b), .writedata(wd_b), .readdata(rd_b),
        .bidir_port(pins_b), .irq(irq_b)
    );

    task automatic wr_a(input logic [2:0] a, input logic [31:0] d);
        @(negedge clk);
        addr_a = a; cs_a = 1'b1; wn_a = 1'b0; wd_a = d;
        @(negedge clk);
        cs_a = 1'b0; wn_a = 1'b1;
    endtask

    task automatic rd_a_reg(input logic [2:0] a, output logic [31:0] d);
        @(negedge clk);
        addr_a = a;
        @(negedge clk);
        d = rd_a;
    endtask

    task automatic wr_b(input logic [2:0] a, input logic [31:0] d);
        @(negedge clk);
        addr_b = a; cs_b = 1'b1; wn_b = 1'b0; wd_b = d;
        @(negedge clk);
        cs_b = 1'b0; wn_b = 1'b1;
    endtask

    task automatic wait_neg(input int n);
        for (int i = 0; i < n; i++) @(negedge clk);
    endtask

    task automatic test_reset;
        logic [31:0] d;
        wait_neg(3);
        tests_run++;
        if (rd_a !== 32'h0) begin
            tests_failed++; $display("FAIL reset_readdata got %h want %h", rd_a, 32'h0);
        end
        tests_run++;
        if (irq_a !== 1'b0) begin
            tests_failed++; $display("FAIL reset_irq got %b want 0", irq_a);
        end
        rst_a = 1'b0;
        rd_a_reg(3'd1, d);
        tests_run++;
        if (d !== 32'h0) begin
            tests_failed++; $display("FAIL reset_dir got %h want %h", d, 32'h0);
        end
        rd_a_reg(3'd2, d);
        tests_run++;
        if (d !== 32'h0) begin
            tests_failed++; $display("FAIL reset_mask got %h want %h", d, 32'h0);
        end
        rd_a_reg(3'd3, d);
        tests_run++;
        if (d !== 32'h0) begin
            tests_failed++; $display("FAIL reset_capture got %h want %h", d, 32'h0);
        end
    endtask

    task automatic test_dir_data;
        logic [31:0] d;
        en_a = 8'h0F; val_a = 8'h0A;
        wr_a(3'd0, 32'hA5);
        wr_a(3'd1, 32'hF0);
        tests_run++;
        if (pins_a[7:4] !== 4'b1010) begin
            tests_failed++; $display("FAIL dir_pins_hi got %b want 1010", pins_a[7:4]);
        end
        @(negedge clk);
        addr_a = 3'd1;
        @(negedge clk);
        tests_run++;
        if (rd_a !== 32'h0000_00F0) begin
            tests_failed++; $display("FAIL dir_readback got %h want %h", rd_a, 32'h0000_00F0);
        end
        wait_neg(2);
        rd_a_reg(3'd0, d);
        tests_run++;
        if (d !== 32'h0000_00AA) begin
            tests_failed++; $display("FAIL data_in_mixed got %h want %h", d, 32'h0000_00AA);
        end
    endtask

    task automatic test_set_clear;
        logic [31:0] d;
        en_a = 8'h00;
        wr_a(3'd1, 32'hFF);
        wr_a(3'd0, 32'h0F);
        tests_run++;
        if (pins_a !== 8'h0F) begin
            tests_failed++; $display("FAIL load_out got %h want %h", pins_a, 8'h0F);
        end
        wr_a(3'd4, 32'h30);
        tests_run++;
        if (pins_a !== 8'h3F) begin
            tests_failed++; $display("FAIL set_out got %h want %h", pins_a, 8'h3F);
        end
        wr_a(3'd5, 32'h05);
        tests_run++;
        if (pins_a !== 8'h3A) begin
            tests_failed++; $display("FAIL clear_out got %h want %h", pins_a, 8'h3A);
        end
        wr_a(3'd6, 32'hFF);
        wr_a(3'd7, 32'h00);
        tests_run++;
        if (pins_a !== 8'h3A) begin
            tests_failed++; $display("FAIL reserved_write got %h want %h", pins_a, 8'h3A);
        end
        rd_a_reg(3'd4, d);
        tests_run++;
        if (d !== 32'h0) begin
            tests_failed++; $display("FAIL read_addr4 got %h want %h", d, 32'h0);
        end
    endtask

    task automatic test_edge_irq;
        wr_a(3'd1, 32'h00);
        val_a = 8'h00; en_a = 8'hFF;
        wait_neg(5);
        wr_a(3'd3, 32'hFF);
        wr_a(3'd2, 32'h01);
        wait_neg(2);
        tests_run++;
        if (irq_a !== 1'b0) begin
            tests_failed++; $display("FAIL edge_pre_irq got %b want 0", irq_a);
        end
        @(negedge clk);
        val_a = 8'h01; addr_a = 3'd3;
        wait_neg(3);
        tests_run++;
        if (irq_a !== 1'b0 || rd_a !== 32'h0) begin
            tests_failed++; $display("FAIL edge_cycle3 got irq=%b rd=%h want irq=0 rd=0", irq_a, rd_a);
        end
        @(negedge clk);
        tests_run++;
        if (irq_a !== 1'b1 || rd_a !== 32'h1) begin
            tests_failed++; $display("FAIL edge_cycle4 got irq=%b rd=%h want irq=1 rd=1", irq_a, rd_a);
        end
        wr_a(3'd3, 32'h01);
        tests_run++;
        if (irq_a !== 1'b1) begin
            tests_failed++; $display("FAIL w1c_irq_hold got %b want 1", irq_a);
        end
        @(negedge clk);
        tests_run++;
        if (irq_a !== 1'b0) begin
            tests_failed++; $display("FAIL w1c_irq_clear got %b want 0", irq_a);
        end
    endtask

    task automatic test_set_wins;
        logic [31:0] d;
        @(negedge clk);
        val_a = 8'h00; addr_a = 3'd3;
        wait_neg(4);
        tests_run++;
        if (rd_a !== 32'h0) begin
            tests_failed++; $display("FAIL falling_ignored got %h want %h", rd_a, 32'h0);
        end
        val_a = 8'h01;
        wait_neg(2);
        cs_a = 1'b1; wn_a = 1'b0; wd_a = 32'h01; addr_a = 3'd3;
        @(negedge clk);
        cs_a = 1'b0; wn_a = 1'b1;
        @(negedge clk);
        tests_run++;
        if (rd_a !== 32'h1 || irq_a !== 1'b1) begin
            tests_failed++; $display("FAIL set_wins got rd=%h irq=%b want rd=1 irq=1", rd_a, irq_a);
        end
        wr_a(3'd3, 32'h01);
        rd_a_reg(3'd3, d);
        tests_run++;
        if (d !== 32'h0) begin
            tests_failed++; $display("FAIL w1c_alone got %h want %h", d, 32'h0);
        end
    endtask

    task automatic test_warmup;
        logic [31:0] d;
        @(negedge clk);
        en_a = 8'hFF; val_a = 8'hFF; rst_a = 1'b1;
        wait_neg(3);
        rst_a = 1'b0;
        wait_neg(2);
        rst_a = 1'b1;
        wait_neg(2);
        rst_a = 1'b0;
        addr_a = 3'd3;
        wait_neg(10);
        tests_run++;
        if (rd_a !== 32'h0 || irq_a !== 1'b0) begin
            tests_failed++; $display("FAIL warmup_capture got rd=%h irq=%b want rd=0 irq=0", rd_a, irq_a);
        end
        rd_a_reg(3'd0, d);
        tests_run++;
        if (d !== 32'h0000_00FF) begin
            tests_failed++; $display("FAIL warmup_data_in got %h want %h", d, 32'h0000_00FF);
        end
    endtask

    task automatic test_wide_any;
        logic [31:0] d;
        @(negedge clk);
        rst_b = 1'b0; addr_b = 3'd3;
        wait_neg(8);
        tests_run++;
        if (rd_b !== 32'h0) begin
            tests_failed++; $display("FAIL wide_warmup got %h want %h", rd_b, 32'h0);
        end
        val_b = 32'h0;
        wait_neg(4);
        tests_run++;
        if (rd_b !== 32'h8000_0000 || irq_b !== 1'b0) begin
            tests_failed++; $display("FAIL wide_fall got rd=%h irq=%b want rd=80000000 irq=0", rd_b, irq_b);
        end
        wr_b(3'd2, 32'h8000_0000);
        tests_run++;
        if (irq_b !== 1'b0) begin
            tests_failed++; $display("FAIL wide_mask_lat got %b want 0", irq_b);
        end
        @(negedge clk);
        tests_run++;
        if (irq_b !== 1'b1) begin
            tests_failed++; $display("FAIL wide_mask_irq got %b want 1", irq_b);
        end
        wr_b(3'd3, 32'hFFFF_FFFF);
        val_b = 32'h0000_0001;
        addr_b = 3'd3;
        wait_neg(5);
        d = rd_b;
        tests_run++;
        if (d !== 32'h0000_0001 || irq_b !== 1'b0) begin
            tests_failed++; $display("FAIL wide_rise got rd=%h irq=%b want rd=00000001 irq=0", d, irq_b);
        end
    endtask

    initial begin
        test_reset();
        test_dir_data();
        test_set_clear();
        test_edge_irq();
        test_set_wins();
        test_warmup();
        test_wide_any();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
